// File: rtl/hazard_ctrl.sv
// Pipeline hazard and flush controller for the 5-stage RV32I core.
// It produces stall and flush controls for the IF/ID, ID/EX and EX/MEM
// registers, and a branch redirect. It also keeps saturating counters
// for stall cycles and mispredicts.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RUN       | normal issue; a load-use hazard inserts one bubble
// LU_BUBBLE | a bubble has just been inserted; the load-use check is masked
// MEM_WAIT  | data memory held the pipe; rec_cnt keeps any pending squash
// RECOVER   | front end is refilling after a redirect; IF/ID is flushed
module hazard_ctrl #(
  parameter int RECOVER_CYCLES = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             use_rs1D,
  input  logic             use_rs2D,
  input  logic             MemReadE,
  input  logic [4:0]       rdE,
  input  logic             branch_validE,
  input  logic             actual_takenE,
  input  logic [31:0]      actual_targetE,
  input  logic             pred_takenE,
  input  logic [31:0]      pred_targetE,
  input  logic [31:0]      pcE,
  input  logic             dmem_busy,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT, RECOVER} state_t;

  localparam logic [2:0]       REC_INIT = 3'(RECOVER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state, state_nx;
  logic [2:0] rec_cnt, rec_cnt_nx;
  logic       lu, mp;
  logic [31:0] pc_plus4;

  assign lu = MemReadE && (rdE != 5'd0) &&
              ((use_rs1D && (rs1D == rdE)) || (use_rs2D && (rs2D == rdE)));
  assign mp = branch_validE &&
              ((actual_takenE != pred_takenE) ||
               (actual_takenE && (actual_targetE != pred_targetE)));
  assign pc_plus4 = pcE + 32'd4;

  // Next-state and control outputs, priority dmem_busy > mispredict > load-use.
  always_comb begin
    stallF         = 1'b0;
    stallD         = 1'b0;
    stallE         = 1'b0;
    stallM         = 1'b0;
    flushD         = 1'b0;
    flushE         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    state_nx       = state;
    rec_cnt_nx     = rec_cnt;
    if (!reset_n) begin
      state_nx   = RUN;
      rec_cnt_nx = '0;
    end else begin
      redirect_pc = actual_takenE ? actual_targetE : pc_plus4;
      if (dmem_busy) begin
        // Whole pipe holds; the branch in EX is re-evaluated once memory frees up.
        stallF   = 1'b1;
        stallD   = 1'b1;
        stallE   = 1'b1;
        stallM   = 1'b1;
        state_nx = MEM_WAIT;
      end else if (mp) begin
        redirect_valid = 1'b1;
        flushD         = 1'b1;
        flushE         = 1'b1;
        rec_cnt_nx     = REC_INIT;
        state_nx       = (REC_INIT == 3'd0) ? RUN : RECOVER;
      end else begin
        unique case (state)
          RUN: begin
            if (lu) begin
              stallF   = 1'b1;
              stallD   = 1'b1;
              flushE   = 1'b1;
              state_nx = LU_BUBBLE;
            end
          end
          LU_BUBBLE: state_nx = RUN;
          MEM_WAIT: begin
            // A squash interrupted by the memory stall resumes first.
            if (rec_cnt != 3'd0) begin
              state_nx = RECOVER;
            end else if (lu) begin
              stallF   = 1'b1;
              stallD   = 1'b1;
              flushE   = 1'b1;
              state_nx = LU_BUBBLE;
            end else begin
              state_nx = RUN;
            end
          end
          RECOVER: begin
            flushD     = 1'b1;
            rec_cnt_nx = (rec_cnt == 3'd0) ? 3'd0 : rec_cnt - 3'd1;
            if (rec_cnt <= 3'd1) state_nx = RUN;
          end
          default: state_nx = RUN;
        endcase
      end
    end
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      rec_cnt     <= '0;
      stall_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      state   <= state_nx;
      rec_cnt <= rec_cnt_nx;
      if (stallF && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect_valid && (mispred_cnt != CNT_MAX)) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule
